fp_mul_iterative: RTL and testbench
===================================

Name: fp_mul_iterative

Overview:
- Sequential IEEE-754 single-precision multiplier; the counterpart to the division datapath in the floating-point arithmetic block.
- Exponent path computes exp_a + exp_b − BIAS + adjustment. This mirrors the divider's exp_a − exp_b + BIAS − adjustment.
- Mantissa product is formed by a 24-step shift-add loop, then normalised and rounded round-to-nearest-even.
- Driven by a start/valid handshake from the arithmetic controller.

Parameters:
- EXP_W, 8, exponent field width.
- MANT_W, 23, stored fraction width; hidden bit is added internally.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- ready  output  1  high in IDLE.
- busy  output  1  high in MULT and NORM.
- valid  output  1  one-cycle pulse; result/flags are valid.
- result  output  32  product; held until the next accepted start.
- overflow  output  1  result saturated to ±inf.
- underflow  output  1  result flushed to ±0.
- invalid  output  1  NaN produced.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, busy=0, valid=0, result=0, all flags=0.
- Reset has priority over everything; asserting it mid-operation aborts with no valid pulse.
- States: IDLE → MULT → NORM → DONE → IDLE.
- IDLE:
  - start=1 at edge E0 latches a and b, sign = a[31]^b[31], and special-case class; goes to MULT with cnt=0.
  - Clears valid/flags of the previous result; result register itself holds its old value.
- MULT (edges E1..E24):
  - Each edge: if multiplier LSB=1, add the 24-bit multiplicand into the 48-bit accumulator; shift multiplier right, multiplicand left; cnt++.
  - Hidden bit = 1 unless the exponent field is 0.
  - At cnt=23 (edge E24) go to NORM.
- NORM (edge E25):
  - adjustment = product[47]. If 1, the significand is product[46:24] with guard at product[23]; else take it one bit lower.
  - Sticky = OR of all remaining lower bits.
  - RNE: increment when guard & (sticky | lsb).
  - If rounding carries out of the 24 bits, shift right one and add 1 to the exponent.
  - Exponent is computed in signed EXP_W+2 bits: exp_a + exp_b − BIAS + adjustment (+ round carry).
  - Write result and flags; go to DONE.
- DONE: valid=1 for exactly this cycle; ready=0. Next edge → IDLE.
- Latency: start accepted at E0; valid high during the cycle after E25. Fixed for all inputs, including special cases.
- start while ready=0 is ignored, not queued. start and rst together: rst wins.
- Range (after rounding):
  - exponent ≥ 255 → {sign, 0xFF, 0}, overflow=1.
  - exponent ≤ 0 → {sign, 0x00, 0}, underflow=1. Subnormals are not produced; subnormal inputs are treated as zero (exp field 0).
- Specials (decided at E0; the loop still runs for fixed latency):
  - Either operand NaN, or inf×0 → 0x7FC00000, invalid=1.
  - Either operand inf, other nonzero → {sign, 0xFF, 0}; overflow stays 0.
  - Either operand zero → {sign, 0x00, 0}; underflow stays 0.
- Flags are mutually exclusive and hold with result until the next accepted start or reset.

Test Plan:
- 0x40000000 × 0x40400000 (2.0×3.0) → result 0x40C00000, no flags, valid exactly 26 edges after the accept edge, busy high 25 cycles.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5, adjustment=1) → 0x40100000. Then 0x3F800001 × 0x3F800001 → 0x3F800002 (RNE drops the 2^-46 term).
- 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1. 0x00800000 × 0x00800000 → 0x00000000, underflow=1.
- 0x80000000 × 0x40400000 → 0x80000000, no flags. 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1. 0xFF800000 × 0x40000000 → 0xFF800000.
- Start pulsed again on cycles 5 and 20 while busy → ignored; only one valid pulse, result of the first operands.
- rst asserted 10 cycles after accept → next cycle ready=1, busy=0, result=0; no valid pulse ever appears. A new start then completes normally.

Source files
------------

// File: rtl/fp_mul_iterative.sv
// Sequential IEEE-754 single-precision multiplier: 24-step shift-add mantissa loop,
// then normalise, round-to-nearest-even and range/special-case packing.
module fp_mul_iterative #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [EXP_W+MANT_W:0]       a,
    input  logic [EXP_W+MANT_W:0]       b,
    output logic                        ready,
    output logic                        busy,
    output logic                        valid,
    output logic [EXP_W+MANT_W:0]       result,
    output logic                        overflow,
    output logic                        underflow,
    output logic                        invalid
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int SW = MANT_W + 1;
    localparam int PW = 2 * SW;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_NORM, S_DONE} state_t;
    typedef enum logic [1:0] {C_NORMAL, C_NAN, C_INF, C_ZERO} class_t;

    state_t                 r_state;
    class_t                 r_class;
    logic [4:0]             r_cnt;
    logic [PW-1:0]          r_mcand;
    logic [SW-1:0]          r_mplier;
    logic [PW-1:0]          r_acc;
    logic                   r_sign;
    logic signed [XW-1:0]   r_exp_sum;
    logic [W-1:0]           r_result;
    logic                   r_ovf, r_unf, r_inv;
    logic                   r_ready, r_busy, r_valid;

    // Round-to-nearest-even on a SW-bit significand; bit SW of the return is the carry-out.
    function automatic logic [SW:0] round_rne(input logic [SW-1:0] m, input logic g, input logic s);
        return {1'b0, m} + {{SW{1'b0}}, g & (s | m[0])};
    endfunction

    // Pack a finite result, saturating to inf or flushing to zero; returns {ovf, unf, word}.
    function automatic logic [W+1:0] saturate(input logic sgn, input logic signed [XW-1:0] e,
                                              input logic [MANT_W-1:0] f);
        if (e >= EXP_MAX)
            return {2'b10, sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        else if (e <= $signed(XW'(0)))
            return {2'b01, sgn, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
        else
            return {2'b00, sgn, e[EXP_W-1:0], f};
    endfunction

    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [MANT_W-1:0] w_fa, w_fb;
    logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    class_t w_class;
    logic signed [XW-1:0] w_exp_sum;

    assign w_ea = a[W-2:MANT_W];
    assign w_eb = b[W-2:MANT_W];
    assign w_fa = a[MANT_W-1:0];
    assign w_fb = b[MANT_W-1:0];
    assign w_a_nan  = (&w_ea) && (|w_fa);
    assign w_b_nan  = (&w_eb) && (|w_fb);
    assign w_a_inf  = (&w_ea) && !(|w_fa);
    assign w_b_inf  = (&w_eb) && !(|w_fb);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(XW'(BIAS));

    always_comb begin
        w_class = C_NORMAL;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            w_class = C_NAN;
        else if (w_a_inf || w_b_inf)
            w_class = C_INF;
        else if (w_a_zero || w_b_zero)
            w_class = C_ZERO;
    end

    // Normalisation: product[47] selects which 24-bit window holds the significand.
    logic                 w_adj, w_guard, w_sticky, w_carry;
    logic [SW-1:0]        w_mant;
    logic [SW:0]          w_rnd;
    logic [MANT_W-1:0]    w_frac;
    logic signed [XW-1:0] w_exp;
    logic [W+1:0]         w_packed;

    assign w_adj    = r_acc[PW-1];
    assign w_mant   = w_adj ? r_acc[PW-1:SW]  : r_acc[PW-2:SW-1];
    assign w_guard  = w_adj ? r_acc[SW-1]     : r_acc[SW-2];
    assign w_sticky = w_adj ? |r_acc[SW-2:0]  : |r_acc[SW-3:0];
    assign w_rnd    = round_rne(w_mant, w_guard, w_sticky);
    assign w_carry  = w_rnd[SW];
    assign w_frac   = w_carry ? w_rnd[MANT_W:1] : w_rnd[MANT_W-1:0];
    assign w_exp    = r_exp_sum + $signed({{(XW-1){1'b0}}, w_adj}) + $signed({{(XW-1){1'b0}}, w_carry});
    assign w_packed = saturate(r_sign, w_exp, w_frac);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_sign    <= a[W-1] ^ b[W-1];
                    r_class   <= w_class;
                    r_exp_sum <= w_exp_sum;
                    r_mcand   <= {{SW{1'b0}}, |w_ea, w_fa};
                    r_mplier  <= {|w_eb, w_fb};
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_valid   <= 1'b0;
                    r_ovf     <= 1'b0;
                    r_unf     <= 1'b0;
                    r_inv     <= 1'b0;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b1;
                    r_state   <= S_MULT;
                end
                S_MULT: begin
                    if (r_mplier[0])
                        r_acc <= r_acc + r_mcand;
                    r_mplier <= r_mplier >> 1;
                    r_mcand  <= r_mcand << 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'(SW - 1))
                        r_state <= S_NORM;
                end
                S_NORM: begin
                    case (r_class)
                        C_NAN: begin
                            r_result <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
                            r_inv    <= 1'b1;
                        end
                        C_INF:  r_result <= {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                        C_ZERO: r_result <= {r_sign, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
                        default: begin
                            r_result <= w_packed[W-1:0];
                            r_ovf    <= w_packed[W+1];
                            r_unf    <= w_packed[W];
                        end
                    endcase
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign result    = r_result;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign invalid   = r_inv;
endmodule

// File: tb/tb_fp_mul_iterative.sv
// Directed bench for fp_mul_iterative: timing, rounding, range, specials,
// ignored starts and mid-operation reset.
module tb_fp_mul_iterative;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        ready, busy, valid, overflow, underflow, invalid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    fp_mul_iterative dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .valid(valid), .result(result),
        .overflow(overflow), .underflow(underflow), .invalid(invalid)
    );

    always #5 clk = ~clk;

    // Runs one operation; k counts negedges after the accept edge, bounded at 40.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input bit poke,
                         output logic [31:0] res, output logic [2:0] flg, output int lat,
                         output int bcnt, output int vcnt, output logic rdy_v);
        res = 'x; flg = 'x; lat = 0; bcnt = 0; vcnt = 0; rdy_v = 'x;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke && (k == 5 || k == 20)) begin
                a = 32'h7F000000; b = 32'h7F000000; start = 1'b1;
            end
            if (busy) bcnt++;
            if (valid) begin
                vcnt++;
                if (lat == 0) begin
                    lat = k; res = result; flg = {overflow, underflow, invalid}; rdy_v = ready;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if ({overflow, underflow, invalid} !== 3'b000) begin bad++;
            $display("FAIL reset_flags got=%b want=000", {overflow, underflow, invalid}); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [31:0] r; logic [2:0] f; int lat, bc, vc; logic rv;
        do_op(32'h40000000, 32'h40400000, 1'b0, r, f, lat, bc, vc, rv);
        total++; if (r !== 32'h40C00000) begin bad++; $display("FAIL basic_result got=%h want=40c00000", r); end
        total++; if (f !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b want=000", f); end
        total++; if (lat !== 26) begin bad++; $display("FAIL basic_latency got=%0d want=26", lat); end
        total++; if (bc !== 25) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=25", bc); end
        total++; if (vc !== 1) begin bad++; $display("FAIL basic_valid_pulses got=%0d want=1", vc); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL basic_ready_in_done got=%b want=0", rv); end
        total++; if (result !== 32'h40C00000) begin bad++; $display("FAIL basic_result_held got=%h want=40c00000", result); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", ready); end
    endtask

    task automatic test_rounding;
        logic [31:0] r; logic [2:0] f; int lat, bc, vc; logic rv;
        logic [31:0] va [4] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00001, 32'h3FFFFFFF};
        logic [31:0] vb [4] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00001, 32'h3FFFFFFF};
        logic [31:0] ve [4] = '{32'h40100000, 32'h3F800002, 32'h40100002, 32'h407FFFFE};
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 1'b0, r, f, lat, bc, vc, rv);
            total++; if (r !== ve[i]) begin bad++;
                $display("FAIL round_%0d got=%h want=%h", i, r, ve[i]); end
            total++; if (f !== 3'b000) begin bad++;
                $display("FAIL round_flags_%0d got=%b want=000", i, f); end
        end
    endtask

    task automatic test_range_specials;
        logic [31:0] r; logic [2:0] f; int lat, bc, vc; logic rv;
        logic [31:0] va [6] = '{32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001};
        logic [31:0] vb [6] = '{32'h7F000000, 32'h00800000, 32'h40400000, 32'h00000000, 32'h40000000, 32'h3F800000};
        logic [31:0] ve [6] = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000};
        logic [2:0]  vf [6] = '{3'b100, 3'b010, 3'b000, 3'b001, 3'b000, 3'b001};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], 1'b0, r, f, lat, bc, vc, rv);
            total++; if (r !== ve[i]) begin bad++;
                $display("FAIL special_%0d got=%h want=%h", i, r, ve[i]); end
            total++; if (f !== vf[i]) begin bad++;
                $display("FAIL special_flags_%0d got=%b want=%b", i, f, vf[i]); end
            total++; if (lat !== 26) begin bad++;
                $display("FAIL special_latency_%0d got=%0d want=26", i, lat); end
        end
    endtask

    task automatic test_ignored_start;
        logic [31:0] r; logic [2:0] f; int lat, bc, vc; logic rv;
        do_op(32'h40000000, 32'h40400000, 1'b1, r, f, lat, bc, vc, rv);
        total++; if (vc !== 1) begin bad++; $display("FAIL ignored_valid_pulses got=%0d want=1", vc); end
        total++; if (r !== 32'h40C00000) begin bad++; $display("FAIL ignored_result got=%h want=40c00000", r); end
        total++; if (f !== 3'b000) begin bad++; $display("FAIL ignored_flags got=%b want=000", f); end
        total++; if (lat !== 26) begin bad++; $display("FAIL ignored_latency got=%0d want=26", lat); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] r; logic [2:0] f; int lat, bc, vc; logic rv;
        int vseen = 0;
        @(negedge clk);
        a = 32'h7F000000; b = 32'h7F000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL abort_result got=%h want=0", result); end
        total++; if ({overflow, underflow, invalid} !== 3'b000) begin bad++;
            $display("FAIL abort_flags got=%b want=000", {overflow, underflow, invalid}); end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (valid) vseen++;
        end
        total++; if (vseen !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", vseen); end
        do_op(32'h40000000, 32'h40400000, 1'b0, r, f, lat, bc, vc, rv);
        total++; if (r !== 32'h40C00000) begin bad++; $display("FAIL abort_recover got=%h want=40c00000", r); end
        total++; if (lat !== 26) begin bad++; $display("FAIL abort_recover_latency got=%0d want=26", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_range_specials();
        test_ignored_start();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
